// File: rtl/fx2_pkg.sv
// Shared constants and helpers for the FX2 IN-endpoint stream arbiter.
// Endpoint addresses, arbitration modes and word-to-byte selection.
package fx2_pkg;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic logic [7:0] byte_of(
    input logic [31:0] word,
    input logic [1:0]  sel
  );
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/stream_ring_buffer.sv
// Per-channel ring buffer with registered fullness and sticky overflow.
// A push into a full buffer is dropped even if a pop happens that cycle.
module stream_ring_buffer
  import fx2_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int AW    = DEPTH_BITS + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  accept;
  logic                  drop;
  logic                  do_pop;

  assign full   = (count == AW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = push && !full;
  assign drop   = push && full;
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Pointer, occupancy and overflow-flag bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + AW'(accept) - AW'(do_pop);
      if (drop)       overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/fx2_stream_arbiter.sv
// Multi-channel word buffering and byte serialisation to FX2 slave FIFOs.
// Data has priority over PKTEND; empty packets are never committed.
module fx2_stream_arbiter
  import fx2_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH_BITS = 2,
  parameter int PKT_BYTES  = 512,
  parameter int ARB_MODE   = ARB_FIXED,
  parameter logic [2*NUM_CH-1:0] EP_ADDRS = {EP6, EP2},
  parameter logic [1:0] IDLE_ADDR = EP4,
  localparam int DATA_W = 8 * WORD_BYTES
) (
  input  logic                     FX2_IFCLK,
  input  logic                     MAX2_RESET,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_flush,
  input  logic                     clear_overflow,
  input  logic [NUM_CH-1:0]        fx2_ep_ready,
  output logic [1:0]               FX2_FIFOADDR,
  output logic                     FX2_SLWR,
  output logic                     FX2_PKTEND,
  output logic [7:0]               fifo_data,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic                     busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW = $clog2(PKT_BYTES);
  localparam int AW = DEPTH_BITS + 1;

  logic [DATA_W-1:0] head [NUM_CH];
  logic [AW-1:0]     cnt  [NUM_CH];
  logic [PW-1:0]     pkt_cnt [NUM_CH];

  logic [NUM_CH-1:0] full_v;
  logic [NUM_CH-1:0] empty_v;
  logic [NUM_CH-1:0] pop_v;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] fl_clr;
  logic [NUM_CH-1:0] flush_pend;

  logic          inflight;
  logic          pick_ok;
  logic          wr_now;
  logic          last;
  logic          fl_ok;
  logic          fl_fire;
  logic [CW-1:0] gnt;
  logic [CW-1:0] pick;
  logic [CW-1:0] cur;
  logic [CW-1:0] rr_last;
  logic [CW-1:0] fl_ch;
  logic [SW-1:0] sel;
  logic [7:0]    byte_now;
  int            idx;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      stream_ring_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH_BITS (DEPTH_BITS)
      ) u_rb (
        .clk      (FX2_IFCLK),
        .rst      (MAX2_RESET),
        .push     (ch_wr[g] & enable),
        .data_in  (ch_data[g*DATA_W +: DATA_W]),
        .pop      (pop_v[g]),
        .clear    (clear_overflow),
        .head     (head[g]),
        .count    (cnt[g]),
        .full     (full_v[g]),
        .empty    (empty_v[g]),
        .overflow (ch_overflow[g])
      );
    end
  endgenerate

  // Pick the next channel to grant and the next flush to service.
  always_comb begin
    elig    = '0;
    pick_ok = 1'b0;
    pick    = '0;
    idx     = 0;
    fl_ok   = 1'b0;
    fl_ch   = '0;
    fl_clr  = '0;
    pop_v   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = (cnt[c] != '0) && fx2_ep_ready[c];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_RR) idx = (int'(rr_last) + 1 + k) % NUM_CH;
      else                    idx = k;
      if (!pick_ok && elig[idx]) begin
        pick_ok = 1'b1;
        pick    = CW'(idx);
      end
    end
    cur    = inflight ? gnt : pick;
    wr_now = inflight ? fx2_ep_ready[gnt] : pick_ok;
    last   = (sel == SW'(WORD_BYTES - 1));
    if (wr_now && last) pop_v[cur] = 1'b1;
    if (!inflight && !pick_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!fl_ok && flush_pend[c] && empty_v[c]) begin
          fl_ok = 1'b1;
          fl_ch = CW'(c);
        end
      end
    end
    if (fl_ok) fl_clr[fl_ch] = 1'b1;
    fl_fire  = fl_ok && (pkt_cnt[fl_ch] != '0);
    byte_now = byte_of(32'(head[cur]), 2'(sel));
  end

  // Word sequencing, packet counting and registered FX2 strobes.
  always_ff @(posedge FX2_IFCLK or posedge MAX2_RESET) begin
    if (MAX2_RESET) begin
      FX2_FIFOADDR <= IDLE_ADDR;
      FX2_SLWR     <= 1'b1;
      FX2_PKTEND   <= 1'b1;
      fifo_data    <= '0;
      busy         <= 1'b0;
      inflight     <= 1'b0;
      gnt          <= '0;
      sel          <= '0;
      rr_last      <= '0;
      flush_pend   <= '0;
      for (int c = 0; c < NUM_CH; c++) pkt_cnt[c] <= '0;
    end else begin
      FX2_FIFOADDR <= IDLE_ADDR;
      FX2_SLWR     <= 1'b1;
      FX2_PKTEND   <= 1'b1;
      busy         <= inflight | (|(~empty_v | full_v));
      flush_pend   <= (flush_pend & ~fl_clr) | ch_flush;
      unique case (1'b1)
        wr_now: begin
          FX2_SLWR     <= 1'b0;
          FX2_FIFOADDR <= EP_ADDRS[{cur, 1'b0} +: 2];
          fifo_data    <= byte_now;
          if (pkt_cnt[cur] == PW'(PKT_BYTES - 1))
            pkt_cnt[cur] <= '0;
          else
            pkt_cnt[cur] <= pkt_cnt[cur] + 1'b1;
          if (!inflight) rr_last <= cur;
          if (last) begin
            inflight <= 1'b0;
            sel      <= '0;
          end else begin
            inflight <= 1'b1;
            sel      <= sel + 1'b1;
            gnt      <= cur;
          end
        end
        fl_fire: begin
          FX2_PKTEND     <= 1'b0;
          FX2_FIFOADDR   <= EP_ADDRS[{fl_ch, 1'b0} +: 2];
          pkt_cnt[fl_ch] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
